// File: rtl/note_history_tracker.sv
// Debounced note history: a note is committed once it repeats STABLE_COUNT
// valid samples in a row and differs from the last committed note.
module note_history_tracker #(
  parameter int unsigned STABLE_COUNT = 4,
  parameter int unsigned DEPTH        = 160
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic [5:0] note_in,
  input  logic       note_valid_in,
  input  logic       clear_in,
  input  logic [7:0] rd_addr_in,
  output logic [5:0] rd_data_out,
  output logic       commit_out,
  output logic [5:0] committed_note_out,
  output logic [7:0] count_out,
  output logic       full_out
);

  localparam int unsigned ADDR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0]  STABLE_RUN = 4'(STABLE_COUNT);
  localparam logic [7:0]  DEPTH_C    = 8'(DEPTH);
  localparam logic [7:0]  LAST_IDX   = 8'(DEPTH - 1);

  typedef enum logic [1:0] {IDLE, TRACK, HOLD} state_t;

  state_t     state;
  logic [5:0] cand;
  logic [3:0] run;
  logic [5:0] last;
  logic [7:0] wr_ptr;
  logic [7:0] count;
  logic [5:0] mem [DEPTH];

  logic       completing;
  logic       commit_w;
  logic [8:0] oldest;
  logic [9:0] rd_sum;
  logic [9:0] rd_phys;

  // The edge that brings the run to STABLE_COUNT; it commits only a new note.
  assign completing = note_valid_in && !clear_in && (state == TRACK) &&
                      (note_in == cand) && ((run + 4'd1) == STABLE_RUN);
  assign commit_w   = completing && (cand != last);

  // Logical-to-physical read mapping relative to the oldest entry.
  always_comb begin
    oldest  = 9'd0;
    rd_sum  = 10'd0;
    rd_phys = 10'd0;
    if ({1'b0, wr_ptr} >= {1'b0, count}) begin
      oldest = {1'b0, wr_ptr} - {1'b0, count};
    end else begin
      oldest = {1'b0, wr_ptr} + 9'(DEPTH) - {1'b0, count};
    end
    rd_sum = {1'b0, oldest} + {2'b00, rd_addr_in};
    if (rd_sum >= 10'(DEPTH)) begin
      rd_phys = rd_sum - 10'(DEPTH);
    end else begin
      rd_phys = rd_sum;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state       <= IDLE;
      cand        <= 6'd0;
      run         <= 4'd0;
      last        <= 6'd0;
      wr_ptr      <= 8'd0;
      count       <= 8'd0;
      commit_out  <= 1'b0;
      rd_data_out <= 6'd0;
    end else begin
      commit_out  <= 1'b0;
      // Read uses pre-update count and pointer, giving read-first behaviour.
      rd_data_out <= (rd_addr_in >= count) ? 6'd0 : mem[ADDR_W'(rd_phys)];
      if (clear_in) begin
        state  <= IDLE;
        run    <= 4'd0;
        last   <= 6'd0;
        wr_ptr <= 8'd0;
        count  <= 8'd0;
      end else if (note_valid_in) begin
        case (state)
          IDLE: begin
            cand  <= note_in;
            run   <= 4'd1;
            state <= TRACK;
          end
          TRACK: begin
            if (note_in == cand) begin
              run <= run + 4'd1;
              if (completing) begin
                state <= HOLD;
                if (commit_w) begin
                  last       <= cand;
                  commit_out <= 1'b1;
                  wr_ptr     <= (wr_ptr == LAST_IDX) ? 8'd0 : wr_ptr + 8'd1;
                  if (count != DEPTH_C) count <= count + 8'd1;
                end
              end
            end else begin
              cand <= note_in;
              run  <= 4'd1;
            end
          end
          HOLD: begin
            if (note_in != cand) begin
              cand  <= note_in;
              run   <= 4'd1;
              state <= TRACK;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // History storage needs no reset; reads are masked by count.
  always_ff @(posedge clk_in) begin
    if (commit_w) mem[ADDR_W'(wr_ptr)] <= cand;
  end

  assign committed_note_out = last;
  assign count_out          = count;
  assign full_out           = (count == DEPTH_C);

endmodule

// File: tb/tb_note_history_tracker.sv
// Scoreboard bench for note_history_tracker with a small history (DEPTH=4).
module tb_note_history_tracker;

  logic       clk_in = 1'b0;
  logic       rst_in = 1'b0;
  logic [5:0] note_in = 6'd0;
  logic       note_valid_in = 1'b0;
  logic       clear_in = 1'b0;
  logic [7:0] rd_addr_in = 8'd0;
  logic [5:0] rd_data_out;
  logic       commit_out;
  logic [5:0] committed_note_out;
  logic [7:0] count_out;
  logic       full_out;

  int checks = 0;
  int failures = 0;
  logic [5:0] exp_q [$];

  note_history_tracker #(.STABLE_COUNT(4), .DEPTH(4)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .note_in(note_in),
    .note_valid_in(note_valid_in), .clear_in(clear_in),
    .rd_addr_in(rd_addr_in), .rd_data_out(rd_data_out),
    .commit_out(commit_out), .committed_note_out(committed_note_out),
    .count_out(count_out), .full_out(full_out)
  );

  always #5 clk_in = ~clk_in;

  // Every commit pulse must match the next expected note in order.
  always @(negedge clk_in) begin
    if (rst_in && commit_out) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_commit got=%0d expected=none", committed_note_out);
      end else begin
        logic [5:0] e;
        e = exp_q.pop_front();
        if (committed_note_out !== e) begin
          failures++;
          $display("FAIL commit_note got=%0d expected=%0d", committed_note_out, e);
        end
      end
    end
  end

  task automatic send(input logic [5:0] n, input int reps, input int gap);
    for (int i = 0; i < reps; i++) begin
      @(negedge clk_in);
      note_in = n;
      note_valid_in = 1'b1;
      for (int j = 0; j < gap; j++) begin
        @(negedge clk_in);
        note_valid_in = 1'b0;
      end
    end
    @(negedge clk_in);
    note_valid_in = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk_in);
  endtask

  task automatic do_clear();
    @(negedge clk_in);
    clear_in = 1'b1;
    note_valid_in = 1'b0;
    @(negedge clk_in);
    clear_in = 1'b0;
  endtask

  task automatic test_reset();
    idle(3);
    checks++;
    if ({commit_out, committed_note_out, rd_data_out, count_out, full_out} !== 22'd0) begin
      failures++;
      $display("FAIL reset_outputs got=%h expected=0",
               {commit_out, committed_note_out, rd_data_out, count_out, full_out});
    end
    rst_in = 1'b1;
    idle(1);
  endtask

  task automatic test_basic_commit();
    exp_q.push_back(6'd12);
    repeat (4) begin
      @(negedge clk_in);
      note_in = 6'd12;
      note_valid_in = 1'b1;
    end
    @(negedge clk_in);
    note_valid_in = 1'b0;
    checks++;
    if (commit_out !== 1'b1) begin
      failures++; $display("FAIL commit_timing got=%b expected=1", commit_out);
    end
    rd_addr_in = 8'd0;
    @(negedge clk_in);
    checks++;
    if (commit_out !== 1'b0) begin
      failures++; $display("FAIL commit_single got=%b expected=0", commit_out);
    end
    checks++;
    if (count_out !== 8'd1 || committed_note_out !== 6'd12) begin
      failures++;
      $display("FAIL basic_state count=%0d note=%0d expected 1/12", count_out, committed_note_out);
    end
    checks++;
    if (rd_data_out !== 6'd12) begin
      failures++; $display("FAIL basic_read got=%0d expected=12", rd_data_out);
    end
    send(6'd12, 3, 0);
    idle(2);
    checks++;
    if (exp_q.size() != 0) begin
      failures++; $display("FAIL basic_missing got=%0d pending expected=0", exp_q.size());
    end
  endtask

  task automatic rd_chk(input logic [7:0] a, input logic [5:0] e);
    @(negedge clk_in);
    rd_addr_in = a;
    @(negedge clk_in);
    checks++;
    if (rd_data_out !== e) begin
      failures++; $display("FAIL read_addr%0d got=%0d expected=%0d", a, rd_data_out, e);
    end
  endtask

  task automatic test_broken_run();
    do_clear();
    exp_q.push_back(6'd12);
    send(6'd12, 2, 0);
    send(6'd7, 1, 0);
    send(6'd12, 4, 0);
    idle(2);
    checks++;
    if (count_out !== 8'd1 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL broken_run count=%0d pending=%0d expected 1/0", count_out, exp_q.size());
    end
  endtask

  task automatic test_hold_dedup();
    do_clear();
    exp_q.push_back(6'd12);
    send(6'd12, 4, 0);
    send(6'd12, 8, 0);
    send(6'd5, 3, 2);
    send(6'd12, 4, 0);
    idle(2);
    checks++;
    if (count_out !== 8'd1) begin
      failures++; $display("FAIL dedup_count got=%0d expected=1", count_out);
    end
    exp_q.push_back(6'd5);
    send(6'd5, 4, 0);
    exp_q.push_back(6'd12);
    send(6'd12, 4, 0);
    idle(2);
    checks++;
    if (count_out !== 8'd3 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL dedup_seq count=%0d pending=%0d expected 3/0", count_out, exp_q.size());
    end
    rd_chk(8'd0, 6'd12);
    rd_chk(8'd1, 6'd5);
    rd_chk(8'd2, 6'd12);
  endtask

  task automatic test_wrap();
    do_clear();
    for (int k = 1; k <= 5; k++) begin
      exp_q.push_back(6'(k));
      send(6'(k), 4, 1);
      if (k == 3) begin
        checks++;
        if (full_out !== 1'b0 || count_out !== 8'd3) begin
          failures++;
          $display("FAIL partial_fill count=%0d full=%b expected 3/0", count_out, full_out);
        end
      end
    end
    idle(2);
    checks++;
    if (full_out !== 1'b1 || count_out !== 8'd4 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL wrap_state count=%0d full=%b pending=%0d expected 4/1/0",
               count_out, full_out, exp_q.size());
    end
    rd_chk(8'd0, 6'd2);
    rd_chk(8'd1, 6'd3);
    rd_chk(8'd2, 6'd4);
    rd_chk(8'd3, 6'd5);
    rd_chk(8'd4, 6'd0);
  endtask

  task automatic test_clear_priority();
    send(6'd7, 3, 0);
    @(negedge clk_in);
    note_in = 6'd7;
    note_valid_in = 1'b1;
    clear_in = 1'b1;
    @(negedge clk_in);
    note_valid_in = 1'b0;
    clear_in = 1'b0;
    checks++;
    if (commit_out !== 1'b0 || count_out !== 8'd0 || full_out !== 1'b0) begin
      failures++;
      $display("FAIL clear_edge commit=%b count=%0d full=%b expected 0/0/0",
               commit_out, count_out, full_out);
    end
    for (int a = 0; a < 4; a++) rd_chk(8'(a), 6'd0);
    exp_q.push_back(6'd9);
    send(6'd9, 4, 0);
    idle(2);
    checks++;
    if (count_out !== 8'd1 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL after_clear count=%0d pending=%0d expected 1/0", count_out, exp_q.size());
    end
    rd_chk(8'd0, 6'd9);
    rd_chk(8'd1, 6'd0);
  endtask

  task automatic test_reset_midrun();
    send(6'd6, 3, 0);
    @(negedge clk_in);
    rst_in = 1'b0;
    @(negedge clk_in);
    checks++;
    if ({commit_out, committed_note_out, rd_data_out, count_out, full_out} !== 22'd0) begin
      failures++;
      $display("FAIL midrun_reset got=%h expected=0",
               {commit_out, committed_note_out, rd_data_out, count_out, full_out});
    end
    rst_in = 1'b1;
    send(6'd6, 1, 0);
    idle(2);
    checks++;
    if (count_out !== 8'd0) begin
      failures++; $display("FAIL no_partial got=%0d expected=0", count_out);
    end
    exp_q.push_back(6'd6);
    send(6'd6, 4, 0);
    idle(2);
    checks++;
    if (count_out !== 8'd1 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL restart count=%0d pending=%0d expected 1/0", count_out, exp_q.size());
    end
  endtask

  task automatic test_back_to_back();
    exp_q.push_back(6'd8);
    send(6'd8, 3, 0);
    @(negedge clk_in);
    note_in = 6'd8;
    note_valid_in = 1'b1;
    rd_addr_in = 8'd1;
    @(negedge clk_in);
    note_valid_in = 1'b0;
    checks++;
    if (rd_data_out !== 6'd0) begin
      failures++; $display("FAIL read_first got=%0d expected=0", rd_data_out);
    end
    @(negedge clk_in);
    checks++;
    if (rd_data_out !== 6'd8) begin
      failures++; $display("FAIL read_after got=%0d expected=8", rd_data_out);
    end
    rd_chk(8'd0, 6'd6);
    checks++;
    if (count_out !== 8'd2 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL b2b_state count=%0d pending=%0d expected 2/0", count_out, exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic_commit();
    test_broken_run();
    test_hold_dedup();
    test_wrap();
    test_clear_priority();
    test_reset_midrun();
    test_back_to_back();
    idle(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/note_history_tracker.md
NOTE_HISTORY_TRACKER -- requirements
Module: note_history_tracker

Interface
REQ-001 SHALL have parameter STABLE_COUNT, default 4: consecutive identical valid notes required to commit; legal range 2..15.
REQ-002 SHALL have parameter DEPTH, default 160: history entries; legal range 2..255.
REQ-003 SHALL have port clk_in, input, 1: sole clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_in, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port note_in, input, 6: note index from note lookup; 0 = rest.
REQ-006 SHALL have port note_valid_in, input, 1: single-cycle qualifier for note_in.
REQ-007 SHALL have port clear_in, input, 1: synchronous history clear.
REQ-008 SHALL have port rd_addr_in, input, 8: logical read index; 0 = oldest entry.
REQ-009 SHALL have port rd_data_out, output, 6: history entry at rd_addr_in.
REQ-010 SHALL have port commit_out, output, 1: single-cycle pulse when a note is appended.
REQ-011 SHALL have port committed_note_out, output, 6: most recently committed note.
REQ-012 SHALL have port count_out, output, 8: number of valid history entries.
REQ-013 SHALL have port full_out, output, 1: high when count_out == DEPTH.

Function
REQ-014 SHALL implement FSM states IDLE, TRACK and HOLD, plus registers cand (6b), run (4b), last (6b), wr_ptr, count.
REQ-015 In IDLE, a valid note SHALL load cand <= note_in and run <= 1, and move to TRACK.
REQ-016 In TRACK, a valid note equal to cand SHALL increment run; when run+1 == STABLE_COUNT, the FSM SHALL move to HOLD and perform the commit check.
REQ-017 In TRACK or HOLD, a valid note not equal to cand SHALL load cand <= note_in and run <= 1, and move to TRACK.
REQ-018 In HOLD, a valid note equal to cand SHALL cause no change; a held note SHALL never produce a second commit.
REQ-019 Commit check: if cand != last, the block SHALL write cand at wr_ptr, set last <= cand, and pulse commit_out in the cycle after the completing edge.
REQ-020 Commit check: if cand == last, the block SHALL not write or pulse, but the FSM SHALL still enter HOLD.
REQ-021 Cycles with note_valid_in low SHALL change no state; they are neither matching nor breaking the run.
REQ-022 wr_ptr SHALL advance on each commit and wrap from DEPTH-1 to 0.
REQ-023 count SHALL increment on each commit and saturate at DEPTH; when full, the oldest entry is overwritten.
REQ-024 The oldest entry's physical index SHALL be (wr_ptr - count) mod DEPTH, and a read SHALL fetch physical (oldest + rd_addr_in) mod DEPTH.
REQ-025 rd_data_out SHALL be registered with 1-cycle latency from rd_addr_in.
REQ-026 rd_data_out SHALL be 0 when rd_addr_in >= count, with count sampled at the same edge.
REQ-027 A read and a commit on the same edge SHALL return pre-write contents and pre-write count/pointer mapping (read-first).
REQ-028 clear_in SHALL set wr_ptr, count, run and last to 0 and the FSM to IDLE, and SHALL suppress commit_out.
REQ-029 clear_in SHALL take priority over note_valid_in on the same edge, and the note presented on that edge SHALL be discarded.
REQ-030 clear_in SHALL not require clearing memory contents; reads are masked by count.
REQ-031 committed_note_out SHALL equal last.
REQ-032 full_out SHALL be combinational from count.

Reset
REQ-033 While rst_in == 0, the FSM SHALL be IDLE, and cand, run, last, wr_ptr and count SHALL be 0.
REQ-034 While rst_in == 0, commit_out, committed_note_out, rd_data_out, count_out and full_out SHALL be 0.
REQ-035 Reset asserted mid-run SHALL abandon the run with no partial commit; after release, the first valid note restarts from IDLE.
REQ-036 Memory contents SHALL not need resetting.

Verification
REQ-037 Scenario: STABLE_COUNT=4; valid notes 12,12,12,12 on consecutive valids -> one commit_out pulse one cycle after the 4th; count_out=1, committed_note_out=12; read addr 0 -> 12 next cycle.
REQ-038 Scenario: 12,12,7,12,12,12,12 -> exactly one commit of 12, after the last note; the 7 commits nothing.
REQ-039 Scenario: commit 12, then 8x12, then 3x5, then 4x12 -> no extra commits; the sequence 12,5,12 with 5 held for 4 commits three entries.
REQ-040 Scenario: DEPTH=4; commit 1,2,3,4,5 -> full_out=1, count_out=4; reads 0..3 -> 2,3,4,5; read 4 -> 0.
REQ-041 Scenario: clear_in asserted on the same edge as a completing 4th note -> no pulse, count_out=0, all reads 0; next 4x9 commits 9 at addr 0.
REQ-042 Scenario: rst_in low for 1 cycle after 3x6, then 1x6 -> no commit; 4 further 6s -> commit.
